// File: rtl/demux_pkg.sv
// Shared definitions for the 1-to-2 stream router.
//   DEMUX_SEL_OUT1 / DEMUX_SEL_OUT2 : in_sel encodings for the two destinations.
//   DEMUX_DEPTH                     : default per-output FIFO depth.
//   demux_clog2()                   : pointer width for a given depth.
// Optional feature macro used by the top level: DEMUX_BYPASS_EN.
package demux_pkg;

  localparam logic DEMUX_SEL_OUT1 = 1'b0;
  localparam logic DEMUX_SEL_OUT2 = 1'b1;

  localparam int unsigned DEMUX_DEPTH = 2;

  // Smallest w with 2**w >= n; evaluated at elaboration only.
  function automatic int unsigned demux_clog2(input int unsigned n);
    int unsigned w;
    w = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(n)) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/demux_fifo.sv
// Small synchronous FIFO used once per router output.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset (clears pointers and count)
//   push        : write push_data (ignored when full)
//   push_data   : word to enqueue
//   full        : count == depth
//   pop         : drop the head word (ignored when empty)
//   head_data   : head word, forced to 0 while empty
//   empty       : count == 0
// depth must be a power of two (>= 2) so the pointers wrap naturally.
module demux_fifo
  import demux_pkg::*;
#(
  parameter int unsigned width = 16,
  parameter int unsigned depth = DEMUX_DEPTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [width-1:0] push_data,
  output logic             full,
  input  logic             pop,
  output logic [width-1:0] head_data,
  output logic             empty
);

  localparam int unsigned PtrW = demux_clog2(depth);
  localparam int unsigned CntW = PtrW + 1;

  logic [width-1:0] mem_q [depth];
  logic [PtrW-1:0]  wptr_q, wptr_d;
  logic [PtrW-1:0]  rptr_q, rptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == CntW'(depth));
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (do_push) wptr_d = wptr_q + PtrW'(1);
    if (do_pop)  rptr_d = rptr_q + PtrW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Storage needs no reset: stale entries are never visible because the head is masked when empty.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= push_data;
  end

  assign head_data = empty ? '0 : mem_q[rptr_q];

endmodule

// File: rtl/stream_demux_1to2.sv
// Registered 1-to-2 stream router. Each accepted input word is queued in the FIFO of the
// destination chosen by in_sel; each output drains independently with valid/ready.
// Ports:
//   clk, rst_n                    : clock, asynchronous active-low reset
//   in_data, in_sel, in_valid     : producer word, destination (0 = out1, 1 = out2), valid
//   in_ready                      : not-full of the selected FIFO (independent of in_valid)
//   out1_data/valid/ready         : consumer 1 handshake, data is the FIFO 1 head
//   out2_data/valid/ready         : consumer 2 handshake, data is the FIFO 2 head
// Optional macro DEMUX_BYPASS_EN: when the selected FIFO is empty and its consumer is ready,
// the input word is forwarded combinationally and not stored.
module stream_demux_1to2
  import demux_pkg::*;
#(
  parameter int unsigned width = 16,
  parameter int unsigned depth = DEMUX_DEPTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [width-1:0] in_data,
  input  logic             in_sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [width-1:0] out1_data,
  output logic             out1_valid,
  input  logic             out1_ready,
  output logic [width-1:0] out2_data,
  output logic             out2_valid,
  input  logic             out2_ready
);

  logic             push1, push2;
  logic             pop1, pop2;
  logic             full1, full2;
  logic             empty1, empty2;
  logic [width-1:0] head1, head2;
  logic             byp1, byp2;
  logic             to_out1, to_out2;

  assign to_out1 = (in_sel == DEMUX_SEL_OUT1);
  assign to_out2 = (in_sel == DEMUX_SEL_OUT2);

  // Registered fullness only: a pop in the same cycle does not free the slot early.
  assign in_ready = to_out2 ? !full2 : !full1;

`ifdef DEMUX_BYPASS_EN
  assign byp1 = in_valid && to_out1 && empty1 && out1_ready;
  assign byp2 = in_valid && to_out2 && empty2 && out2_ready;
`else
  assign byp1 = 1'b0;
  assign byp2 = 1'b0;
`endif

  assign push1 = in_valid && in_ready && to_out1 && !byp1;
  assign push2 = in_valid && in_ready && to_out2 && !byp2;
  assign pop1  = out1_ready && !empty1;
  assign pop2  = out2_ready && !empty2;

  assign out1_valid = !empty1 || byp1;
  assign out2_valid = !empty2 || byp2;
  assign out1_data  = byp1 ? in_data : head1;
  assign out2_data  = byp2 ? in_data : head2;

  demux_fifo #(
    .width (width),
    .depth (depth)
  ) u_fifo1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push1),
    .push_data (in_data),
    .full      (full1),
    .pop       (pop1),
    .head_data (head1),
    .empty     (empty1)
  );

  demux_fifo #(
    .width (width),
    .depth (depth)
  ) u_fifo2 (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push2),
    .push_data (in_data),
    .full      (full2),
    .pop       (pop2),
    .head_data (head2),
    .empty     (empty2)
  );

endmodule

// File: tb/tb_stream_demux_1to2.sv
module tb_stream_demux_1to2;

  localparam int unsigned W     = 16;
  localparam int unsigned DEPTH = 2;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic [W-1:0] in_data = '0;
  logic         in_sel = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] out1_data, out2_data;
  logic         out1_valid, out2_valid;
  logic         out1_ready = 1'b0;
  logic         out2_ready = 1'b0;

  int total = 0;
  int bad   = 0;

  // Reference model: one queue per destination, contents in arrival order.
  logic [W-1:0] q1[$];
  logic [W-1:0] q2[$];
  logic         last_acc;
  logic         prev_stall = 1'b0;
  logic         prev_sel;
  logic [W-1:0] prev_data;

  always #5 clk = ~clk;

  stream_demux_1to2 #(
    .width (W),
    .depth (DEPTH)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_data    (in_data),
    .in_sel     (in_sel),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out1_data  (out1_data),
    .out1_valid (out1_valid),
    .out1_ready (out1_ready),
    .out2_data  (out2_data),
    .out2_valid (out2_valid),
    .out2_ready (out2_ready)
  );

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One clock: check outputs at the falling edge against the model, then advance the model
  // at the rising edge. Inputs are expected to be set before the call.
  task automatic cycle();
    logic         exp_rdy, v1, v2, byp1, byp2, pop1, pop2;
    logic [W-1:0] d1, d2;
    @(negedge clk);
    if (prev_stall) begin
      total++;
      assert (in_valid && in_sel === prev_sel && in_data === prev_data) else begin
        bad++;
        $error("FAIL protocol_hold: sel %b data %h, held sel %b data %h",
               in_sel, in_data, prev_sel, prev_data);
      end
    end
    exp_rdy = (in_sel ? q2.size() : q1.size()) < DEPTH;
    byp1 = 1'b0;
    byp2 = 1'b0;
`ifdef DEMUX_BYPASS_EN
    byp1 = in_valid && !in_sel && q1.size() == 0 && out1_ready;
    byp2 = in_valid &&  in_sel && q2.size() == 0 && out2_ready;
`endif
    v1 = (q1.size() != 0) || byp1;
    v2 = (q2.size() != 0) || byp2;
    d1 = (q1.size() != 0) ? q1[0] : in_data;
    d2 = (q2.size() != 0) ? q2[0] : in_data;
    chk("in_ready", W'(in_ready), W'(exp_rdy));
    chk("out1_valid", W'(out1_valid), W'(v1));
    chk("out2_valid", W'(out2_valid), W'(v2));
    if (v1) chk("out1_data", out1_data, d1);
    if (v2) chk("out2_data", out2_data, d2);
    last_acc   = in_valid && exp_rdy;
    pop1       = (q1.size() != 0) && out1_ready;
    pop2       = (q2.size() != 0) && out2_ready;
    prev_stall = in_valid && !exp_rdy;
    prev_sel   = in_sel;
    prev_data  = in_data;
    @(posedge clk);
    if (pop1) void'(q1.pop_front());
    if (pop2) void'(q2.pop_front());
    if (last_acc && !in_sel && !byp1) q1.push_back(in_data);
    if (last_acc &&  in_sel && !byp2) q2.push_back(in_data);
    #1;
  endtask

  // Offer one word and hold it until accepted (bounded).
  task automatic push_word(input logic sel, input logic [W-1:0] data);
    in_valid = 1'b1;
    in_sel   = sel;
    in_data  = data;
    for (int i = 0; i < 8; i++) begin
      cycle();
      if (last_acc) break;
    end
    total++;
    assert (last_acc === 1'b1) else begin
      bad++;
      $error("FAIL accept_timeout: word %h never accepted (got %b expected 1)", data, last_acc);
    end
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    // Reset from power-up.
    #2 rst_n = 1'b0;
    #1;
    chk("rst_out1_valid", W'(out1_valid), '0);
    chk("rst_out2_valid", W'(out2_valid), '0);
    chk("rst_out1_data", out1_data, '0);
    chk("rst_out2_data", out2_data, '0);
    chk("rst_in_ready", W'(in_ready), W'(1));
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b1;
    idle(1);

    // Basic route, both consumers ready.
    out1_ready = 1'b1;
    out2_ready = 1'b1;
    push_word(1'b0, 16'hA5A5);
    push_word(1'b1, 16'h5A5A);
    idle(3);

    // Backpressure on output 1: third word stalls until the first pop.
    out1_ready = 1'b0;
    push_word(1'b0, 16'h0101);
    push_word(1'b0, 16'h0202);
    in_data = 16'h0303;
    in_sel  = 1'b0;
    cycle();
    cycle();
    out1_ready = 1'b1;
    push_word(1'b0, 16'h0303);
    idle(4);

    // Output 2 keeps flowing while FIFO 1 is full and stalled.
    out1_ready = 1'b0;
    push_word(1'b0, 16'h1111);
    push_word(1'b0, 16'h2222);
    out2_ready = 1'b1;
    for (int k = 1; k <= 4; k++) push_word(1'b1, W'(k));
    idle(2);
    chk("fifo1_still_full", W'(q1.size()), W'(DEPTH));

    // Continuous stream through output 1 with pointer wrap.
    out1_ready = 1'b1;
    idle(3);
    for (int k = 0; k <= 16; k++) push_word(1'b0, W'(k));
    idle(3);

    // Single word into an empty FIFO 2 with its consumer ready.
    push_word(1'b1, 16'hBEEF);
    idle(2);

    // Asynchronous reset with two words queued in FIFO 1.
    out1_ready = 1'b0;
    push_word(1'b0, 16'hDEAD);
    push_word(1'b0, 16'hCAFE);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_out1_valid", W'(out1_valid), '0);
    chk("midrst_out2_valid", W'(out2_valid), '0);
    chk("midrst_out1_data", out1_data, '0);
    chk("midrst_out2_data", out2_data, '0);
    q1.delete();
    q2.delete();
    prev_stall = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b1;
    out1_ready = 1'b1;
    idle(4);

    // Random traffic; words stay put while stalled.
    for (int n = 0; n < 400; n++) begin
      if (!prev_stall) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_sel   = 1'($urandom_range(0, 1));
        in_data  = W'($urandom);
      end
      out1_ready = ($urandom_range(0, 2) != 0);
      out2_ready = ($urandom_range(0, 2) != 0);
      cycle();
    end
    out1_ready = 1'b1;
    out2_ready = 1'b1;
    if (prev_stall) cycle();
    idle(4);
    chk("drained_q1", W'(q1.size()), '0);
    chk("drained_q2", W'(q2.size()), '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
